// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the requesters and the memory around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifReady;
  logic              ifRespValid;
  logic [DATA_W-1:0] ifRdata;
  logic              ifErr;
  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic              dReady;
  logic              dRespValid;
  logic [DATA_W-1:0] dRdata;
  logic              dErr;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] memData;
  logic              busy;

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memData,
    output ifReady, ifRespValid, ifRdata, ifErr,
    output dReady, dRespValid, dRdata, dErr,
    output memRead, memWrite, address, writeData, busy
  );

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memData,
    input  ifReady, ifRespValid, ifRdata, ifErr,
    input  dReady, dRespValid, dRdata, dErr,
    input  memRead, memWrite, address, writeData, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is data-over-fetch priority.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  if (DATA_W != 32) begin : g_width_check
    $error("mem_arbiter supports DATA_W = 32 only");
  end

  state_t            state;
  logic              grant_d;
  logic              grant_i;
  logic              last_grant_d;
  logic              own_d;
  logic              own_we;
  logic              own_fault;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_resp;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_resp;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic              win_fault;

  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_WORD);
  endfunction

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
      if (bus.dReq && bus.ifReq) begin
        grant_d = !last_grant_d;
        grant_i = last_grant_d;
      end else begin
        grant_d = bus.dReq;
        grant_i = bus.ifReq;
      end
`else
      grant_d = bus.dReq;
      grant_i = bus.ifReq && !bus.dReq;
`endif
    end
  end

  assign win_addr  = grant_d ? bus.dAddr : bus.ifAddr;
  assign win_we    = grant_d & bus.dWe;
  assign win_fault = addr_fault(win_addr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      own_d        <= 1'b0;
      own_we       <= 1'b0;
      own_fault    <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_resp      <= 1'b0;
      if_err       <= 1'b0;
      if_rdata     <= '0;
      d_resp       <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      // Pulses and strobes live for one cycle unless re-armed below.
      if_resp      <= 1'b0;
      d_resp       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      // Holds its value when nobody is granted; grants only happen in IDLE.
      last_grant_d <= grant_d | (last_grant_d & ~grant_i);
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            own_d     <= grant_d;
            own_we    <= win_we;
            own_fault <= win_fault;
            if (win_fault) begin
              state <= RESP;
            end else begin
              state   <= ACCESS;
              addr_q  <= win_addr;
              wdata_q <= win_we ? bus.dWdata : '0;
              mem_rd  <= !win_we;
              mem_wr  <= win_we;
            end
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          state <= IDLE;
          if (own_d) begin
            d_resp <= 1'b1;
            d_err  <= own_fault;
            if (!own_we && !own_fault) d_rdata <= bus.memData;
          end else begin
            if_resp <= 1'b1;
            if_err  <= own_fault;
            if (!own_fault) if_rdata <= bus.memData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ifReady     = grant_i;
  assign bus.dReady      = grant_d;
  assign bus.ifRespValid = if_resp;
  assign bus.ifRdata     = if_rdata;
  assign bus.ifErr       = if_err;
  assign bus.dRespValid  = d_resp;
  assign bus.dRdata      = d_rdata;
  assign bus.dErr        = d_err;
  assign bus.memRead     = mem_rd;
  assign bus.memWrite    = mem_wr;
  assign bus.address     = addr_q;
  assign bus.writeData   = wdata_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level memory/arbitration model.
module tb_mem_arbiter;
  logic clk;
  logic resetn;
  int   cyc;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
    logic [31:0] old;
  } strb_t;

  logic [31:0] mem       [0:255];
  logic [31:0] model_mem [0:255];
  resp_t       rsq[$];
  strb_t       stq[$];
  int          free_at;
  bit          mdl_last_d;
  logic [31:0] exp_drdata;

  bit          exp_i, exp_d, flt, we_t;
  logic [31:0] a_t;
  resp_t       r_new, r_got;
  strb_t       s_new, s_got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered single-port memory: read data valid the cycle after memRead.
  always @(posedge clk) begin
    if (bus.memRead)  bus.memData <= mem[bus.address[9:2]];
    if (bus.memWrite) mem[bus.address[9:2]] <= bus.writeData;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'd1020);
  endfunction

  // Arbitration and acceptance model: decides who must be granted each cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      while (stq.size() > 0) begin
        s_got = stq.pop_back();
        if (s_got.we) model_mem[s_got.addr[9:2]] = s_got.old;
      end
      rsq.delete();
      free_at    = 0;
      mdl_last_d = 1'b0;
      exp_drdata = '0;
    end else begin
      exp_i = 1'b0;
      exp_d = 1'b0;
      if (cyc >= free_at) begin
        if (bus.dReq && bus.ifReq) begin
`ifdef MEM_ARB_RR_EN
          exp_d = !mdl_last_d;
          exp_i = mdl_last_d;
`else
          exp_d = 1'b1;
`endif
        end else begin
          exp_d = bus.dReq;
          exp_i = bus.ifReq;
        end
      end
      chk("ifReady", {31'b0, bus.ifReady}, {31'b0, exp_i});
      chk("dReady", {31'b0, bus.dReady}, {31'b0, exp_d});
      chk("busy", {31'b0, bus.busy}, {31'b0, (cyc < free_at)});
      if (exp_d || exp_i) begin
        a_t  = exp_d ? bus.dAddr : bus.ifAddr;
        we_t = exp_d && bus.dWe;
        flt  = is_fault(a_t);
        r_new.is_d = exp_d;
        r_new.err  = flt;
        r_new.due  = cyc + (flt ? 2 : 3);
        r_new.data = '0;
        if (!flt) begin
          s_new.we    = we_t;
          s_new.addr  = a_t;
          s_new.wdata = bus.dWdata;
          s_new.due   = cyc + 1;
          s_new.old   = model_mem[a_t[9:2]];
          if (we_t) begin
            model_mem[a_t[9:2]] = bus.dWdata;
            r_new.data = exp_drdata;
          end else begin
            r_new.data = model_mem[a_t[9:2]];
            if (exp_d) exp_drdata = r_new.data;
          end
          stq.push_back(s_new);
        end
        rsq.push_back(r_new);
        free_at    = r_new.due;
        mdl_last_d = exp_d;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (rsq.size() > 0 && rsq[0].due < cyc) begin
        fail_now("missing_response");
        void'(rsq.pop_front());
      end
      if (bus.ifRespValid && bus.dRespValid) begin
        fail_now("both_resp_valid");
      end else if (bus.ifRespValid || bus.dRespValid) begin
        if (rsq.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          r_got = rsq.pop_front();
          chk("resp_port_is_data", {31'b0, bus.dRespValid}, {31'b0, r_got.is_d});
          chk("resp_cycle", cyc, r_got.due);
          chk("resp_err", {31'b0, bus.dRespValid ? bus.dErr : bus.ifErr}, {31'b0, r_got.err});
          if (!r_got.err)
            chk("resp_rdata", bus.dRespValid ? bus.dRdata : bus.ifRdata, r_got.data);
        end
      end
    end
  end

  // Memory strobe monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (stq.size() > 0 && stq[0].due < cyc) begin
        fail_now("missing_strobe");
        void'(stq.pop_front());
      end
      if (bus.memRead && bus.memWrite) begin
        fail_now("read_and_write_strobe");
      end else if (bus.memRead || bus.memWrite) begin
        if (stq.size() == 0) begin
          fail_now("unexpected_strobe");
        end else begin
          s_got = stq.pop_front();
          chk("strobe_cycle", cyc, s_got.due);
          chk("strobe_is_write", {31'b0, bus.memWrite}, {31'b0, s_got.we});
          chk("strobe_address", bus.address, s_got.addr);
          if (s_got.we) chk("strobe_wdata", bus.writeData, s_got.wdata);
        end
      end else begin
        chk("idle_address", bus.address, 32'h0);
        chk("idle_writeData", bus.writeData, 32'h0);
      end
    end
  end

  task automatic all_zero(input string tag);
    chk({tag, "_ifReady"}, {31'b0, bus.ifReady}, 32'h0);
    chk({tag, "_ifRespValid"}, {31'b0, bus.ifRespValid}, 32'h0);
    chk({tag, "_ifRdata"}, bus.ifRdata, 32'h0);
    chk({tag, "_ifErr"}, {31'b0, bus.ifErr}, 32'h0);
    chk({tag, "_dReady"}, {31'b0, bus.dReady}, 32'h0);
    chk({tag, "_dRespValid"}, {31'b0, bus.dRespValid}, 32'h0);
    chk({tag, "_dRdata"}, bus.dRdata, 32'h0);
    chk({tag, "_dErr"}, {31'b0, bus.dErr}, 32'h0);
    chk({tag, "_memRead"}, {31'b0, bus.memRead}, 32'h0);
    chk({tag, "_memWrite"}, {31'b0, bus.memWrite}, 32'h0);
    chk({tag, "_address"}, bus.address, 32'h0);
    chk({tag, "_writeData"}, bus.writeData, 32'h0);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'h0);
  endtask

  // Drivers start and end at 1 time unit after a rising edge.
  task automatic do_if(input logic [31:0] a, input int lim, input bit must, output int acc);
    acc = -1;
    bus.ifReq  = 1'b1;
    bus.ifAddr = a;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.ifReady) acc = cyc;
      @(posedge clk);
      #1;
      if (acc >= 0) break;
    end
    bus.ifReq = 1'b0;
    if (must && acc < 0) fail_now("fetch_accept_timeout");
  endtask

  task automatic do_d(input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input int lim, input bit must, output int acc);
    acc = -1;
    bus.dReq   = 1'b1;
    bus.dWe    = w;
    bus.dAddr  = a;
    bus.dWdata = wd;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.dReady) acc = cyc;
      @(posedge clk);
      #1;
      if (acc >= 0) break;
    end
    bus.dReq = 1'b0;
    if (must && acc < 0) fail_now("data_accept_timeout");
  endtask

  function automatic logic [31:0] rand_addr();
    int          sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    a   = 32'($urandom_range(0, 255)) << 2;
    if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
    if (sel == 1) a = 32'h400 + (32'($urandom_range(0, 63)) << 2);
    return a;
  endfunction

  int acc_a, acc_b, acc_c, acc_d, acc_i;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    resetn   = 1'b0;
    bus.ifReq = 1'b0; bus.ifAddr = '0;
    bus.dReq = 1'b0; bus.dWe = 1'b0; bus.dAddr = '0; bus.dWdata = '0;
    bus.memData = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    mem[0]  = 32'h0000_2083;
    mem[14] = 32'h0000_0005;
    for (int i = 0; i < 256; i++) model_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, then store/load round trip to the same word.
    do_if(32'h0, 20, 1, acc_a);
    do_d(1'b1, 32'h4, 32'h0000_000F, 20, 1, acc_a);
    do_d(1'b0, 32'h4, 32'h0, 20, 1, acc_a);

    // Simultaneous requests; the previous winner was the data port.
    fork
      do_d(1'b0, 32'h38, 32'h0, 20, 1, acc_d);
      do_if(32'h10, 20, 1, acc_i);
    join
`ifdef MEM_ARB_RR_EN
    chk("arb_fetch_first", {31'b0, (acc_i < acc_d)}, 32'h1);
`else
    chk("arb_data_first", {31'b0, (acc_d < acc_i)}, 32'h1);
`endif
    chk("arb_second_grant_gap", (acc_d > acc_i) ? acc_d - acc_i : acc_i - acc_d, 32'd3);

    // Faulting accesses, then an aligned load clears the error.
    do_d(1'b0, 32'h6, 32'h0, 20, 1, acc_a);
    do_d(1'b0, 32'h400, 32'h0, 20, 1, acc_a);
    do_d(1'b1, 32'h3FE, 32'h1234_5678, 20, 1, acc_a);
    do_d(1'b0, 32'h10, 32'h0, 20, 1, acc_a);

    // Reset during the ACCESS cycle of a store.
    do_d(1'b1, 32'h8, 32'hDEAD_BEEF, 20, 1, acc_a);
    #2;
    resetn = 1'b0;
    #1;
    all_zero("midreset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("post_reset_busy", {31'b0, bus.busy}, 32'h0);
    do_d(1'b0, 32'h8, 32'h0, 20, 1, acc_a);

    // Back-to-back fetches with ifReq held.
    do_if(32'h0, 20, 1, acc_a);
    do_if(32'h4, 20, 1, acc_b);
    do_if(32'h8, 20, 1, acc_c);
    chk("b2b_gap_1", acc_b - acc_a, 32'd3);
    chk("b2b_gap_2", acc_c - acc_b, 32'd3);

    // Random traffic on both ports, including cancelled requests.
    fork
      begin
        int acc_r;
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_if(rand_addr(), $urandom_range(1, 8), 0, acc_r);
        end
      end
      begin
        int acc_s;
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          do_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, $urandom_range(1, 8), 0, acc_s);
        end
      end
    join

    for (int i = 0; i < 30 && (rsq.size() > 0 || stq.size() > 0); i++) @(posedge clk);
    #1;
    chk("drain_responses", rsq.size(), 32'h0);
    chk("drain_strobes", stq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
